// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller
// Description : Main control FSM of the multi-cycle datapath. Sequences
//               fetch/decode/execute/memory/writeback, drives the ALU op and
//               operand selects, resolves branches from the ALU zero/negative
//               flags and handshakes with the shared memory via mem_ready.
//               Optional macro CTRL_INSTR_CNT_EN adds the retired-instruction
//               counter output instr_count.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_controller #(
    parameter int OPCODE_W = 4
`ifdef CTRL_INSTR_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zer_flag,
    input  logic                neg_flag,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                pc_write,
    output logic                illegal_op
`ifdef CTRL_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0]    instr_count
`endif
);

    localparam logic [OPCODE_W-1:0] c_OP_ADD  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] c_OP_SUB  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] c_OP_AND  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] c_OP_OR   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] c_OP_ADDI = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] c_OP_LW   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] c_OP_SW   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] c_OP_BZ   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] c_OP_BN   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] c_OP_JMP  = OPCODE_W'(9);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [OPCODE_W-1:0]   r_opcode;

    // State register; reset parks the FSM in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the opcode in DECODE so later states never re-sample the IR field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Next-state and Moore/Mealy control outputs; reset forces every output low.
    always_comb begin
        w_next     = r_state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed with the fetch.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: w_next = S_EXEC_R;
                    c_OP_ADDI:                             w_next = S_EXEC_I;
                    c_OP_LW, c_OP_SW:                      w_next = S_MEM_ADDR;
                    c_OP_BZ, c_OP_BN:                      w_next = S_BRANCH;
                    c_OP_JMP:                              w_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                // R-type opcodes 0..3 map directly onto the ALU op encoding.
                alu_src_a = 1'b1;
                alu_op    = r_opcode[1:0];
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (r_opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                // Compare A-B; the flags of this very cycle decide the PC load.
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = ((r_opcode == c_OP_BZ) & zer_flag) |
                            ((r_opcode == c_OP_BN) & neg_flag);
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                w_next   = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Requests and write enables must vanish the instant reset asserts.
        if (!rst_n) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            pc_write   = 1'b0;
            illegal_op = 1'b0;
        end
    end

`ifdef CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] r_instr_count;

    // Count every return to FETCH, illegal opcodes included; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if ((r_state != S_FETCH) && (w_next == S_FETCH)) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_controller
// Description : Self-checking bench for multi_cycle_controller: directed
//               vector table, hand-written stall/reset/counter sequences and
//               randomized instruction streams against a sequence model.
//               Define CTRL_INSTR_CNT_EN to also check instr_count (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;

    localparam int c_OPCODE_W = 4;
    localparam int c_CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic       zer_flag = 1'b0;
    logic       neg_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst;
    logic       mem_to_reg, alu_src_a, pc_write, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
`ifdef CTRL_INSTR_CNT_EN
    logic [c_CNT_W-1:0] instr_count;
`endif

    always #5 clk = ~clk;

    multi_cycle_controller #(
        .OPCODE_W (c_OPCODE_W)
`ifdef CTRL_INSTR_CNT_EN
        ,
        .CNT_W    (c_CNT_W)
`endif
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zer_flag   (zer_flag),
        .neg_flag   (neg_flag),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .illegal_op (illegal_op)
`ifdef CTRL_INSTR_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       illegal_op;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic       zf;
        logic       nf;
        logic       mr;
        out_t       exp;
    } vec_t;

    out_t w_act;
    assign w_act = '{mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                     pc_write, illegal_op};

    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;   // instructions retired since the last reset
    vec_t tbl[$];
    vec_t q[$];

    // ---------------- expected output per micro-step, from the op rules ----
    function automatic out_t o_fetch(logic mr);
        out_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr;
        return o;
    endfunction
    function automatic out_t o_decode(logic ill);
        out_t o = '0;
        o.alu_src_b = 2'b11; o.illegal_op = ill;
        return o;
    endfunction
    function automatic out_t o_exec_r(logic [1:0] aop);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = aop;
        return o;
    endfunction
    function automatic out_t o_wb(logic dst, logic m2r);
        out_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r;
        return o;
    endfunction
    function automatic out_t o_addr();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic out_t o_mem(logic wr);
        out_t o = '0;
        o.mem_read = ~wr; o.mem_write = wr; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic out_t o_branch(logic take);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_write = take;
        return o;
    endfunction
    function automatic out_t o_jump();
        out_t o = '0;
        o.pc_src = 2'b10; o.pc_write = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(logic [3:0] op, logic zf, logic nf, logic mr, out_t e);
        vec_t v;
        v.op = op; v.zf = zf; v.nf = nf; v.mr = mr; v.exp = e;
        return v;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its cycle-by-cycle stimulus/expectation list.
    task automatic gen_instr(input int op, input int sf, input int sm);
        logic [3:0] o4;
        logic       zf, nf, take;
        o4 = op[3:0];
        for (int i = 0; i < sf; i++) q.push_back(mk(o4, rb(), rb(), 1'b0, o_fetch(1'b0)));
        q.push_back(mk(o4, rb(), rb(), 1'b1, o_fetch(1'b1)));
        q.push_back(mk(o4, rb(), rb(), rb(), o_decode(op >= 10)));
        case (op)
            0, 1, 2, 3: begin
                q.push_back(mk(o4, rb(), rb(), rb(), o_exec_r(o4[1:0])));
                q.push_back(mk(o4, rb(), rb(), rb(), o_wb(1'b1, 1'b0)));
            end
            4: begin
                q.push_back(mk(o4, rb(), rb(), rb(), o_addr()));
                q.push_back(mk(o4, rb(), rb(), rb(), o_wb(1'b0, 1'b0)));
            end
            5, 6: begin
                q.push_back(mk(o4, rb(), rb(), rb(), o_addr()));
                for (int i = 0; i < sm; i++)
                    q.push_back(mk(o4, rb(), rb(), 1'b0, o_mem(op == 6)));
                q.push_back(mk(o4, rb(), rb(), 1'b1, o_mem(op == 6)));
                if (op == 5) q.push_back(mk(o4, rb(), rb(), rb(), o_wb(1'b0, 1'b1)));
            end
            7, 8: begin
                zf   = rb();
                nf   = rb();
                take = (op == 7) ? zf : nf;
                q.push_back(mk(o4, zf, nf, rb(), o_branch(take)));
            end
            9: q.push_back(mk(o4, rb(), rb(), rb(), o_jump()));
            default: ;
        endcase
    endtask

    task automatic chk(input out_t e, input string nm, input int idx);
        checks++;
        if (w_act !== e) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, w_act, e);
        end
    endtask

    task automatic chk_cnt(input string nm);
`ifdef CTRL_INSTR_CNT_EN
        checks++;
        if (instr_count !== c_CNT_W'(m_cnt)) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, instr_count, c_CNT_W'(m_cnt));
        end
`else
        if (nm.len() == 0) $display("empty counter tag");
`endif
    endtask

    // Drive one cycle's inputs, compare mid-cycle, then step past the edge.
    task automatic apply(input vec_t v, input string nm, input int idx);
        opcode = v.op; zer_flag = v.zf; neg_flag = v.nf; mem_ready = v.mr;
        @(negedge clk);
        chk(v.exp, nm, idx);
        @(posedge clk);
        #1;
    endtask

    task automatic run_q(input string nm);
        int n = 0;
        while (q.size() > 0) begin
            apply(q.pop_front(), nm, n);
            n++;
        end
        m_cnt++;
    endtask

    initial begin
        // Directed table: ADD, BZ taken/not taken, BN taken, illegal opcode 12.
        tbl.push_back(mk(4'd0, 0, 0, 1, o_fetch(1'b1)));
        tbl.push_back(mk(4'd0, 0, 0, 1, o_decode(1'b0)));
        tbl.push_back(mk(4'd0, 0, 0, 1, o_exec_r(2'd0)));
        tbl.push_back(mk(4'd0, 0, 0, 1, o_wb(1'b1, 1'b0)));
        tbl.push_back(mk(4'd7, 0, 0, 1, o_fetch(1'b1)));
        tbl.push_back(mk(4'd7, 0, 0, 1, o_decode(1'b0)));
        tbl.push_back(mk(4'd7, 1, 0, 1, o_branch(1'b1)));
        tbl.push_back(mk(4'd7, 0, 0, 1, o_fetch(1'b1)));
        tbl.push_back(mk(4'd7, 0, 0, 1, o_decode(1'b0)));
        tbl.push_back(mk(4'd7, 0, 1, 1, o_branch(1'b0)));
        tbl.push_back(mk(4'd8, 0, 0, 1, o_fetch(1'b1)));
        tbl.push_back(mk(4'd8, 0, 0, 1, o_decode(1'b0)));
        tbl.push_back(mk(4'd8, 0, 1, 1, o_branch(1'b1)));
        tbl.push_back(mk(4'd12, 0, 0, 1, o_fetch(1'b1)));
        tbl.push_back(mk(4'd12, 0, 0, 1, o_decode(1'b1)));
        tbl.push_back(mk(4'd3, 0, 0, 1, o_fetch(1'b1)));

        // Reset held: every output low even though the FSM sits in FETCH.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk('0, "reset_outputs", 0);
        chk_cnt("reset_count");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table", i);
        m_cnt = 5;   // ADD, BZ, BZ, BN, illegal retired; OR fetch is in progress
        // Finish the OR instruction started by the last table row.
        q.push_back(mk(4'd3, 0, 0, 0, o_decode(1'b0)));
        q.push_back(mk(4'd3, 0, 0, 0, o_exec_r(2'd3)));
        q.push_back(mk(4'd3, 0, 0, 0, o_wb(1'b1, 1'b0)));
        run_q("or_tail");
        chk_cnt("count_after_table");

        // LW with three stalled memory cycles, and a stalled fetch.
        gen_instr(5, 2, 3);
        run_q("lw_stall");

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            gen_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
            run_q("rand");
        end
        chk_cnt("count_after_random");

        // SW stalled in MEM_WR, then reset asserted mid-access.
        gen_instr(6, 0, 4);
        for (int i = 0; i < 4; i++) apply(q.pop_front(), "sw_pre_reset", i);
        q.delete();
        opcode = 4'd6; mem_ready = 1'b0;
        @(negedge clk);
        chk(o_mem(1'b1), "sw_mem_wr_held", 0);
        #1 rst_n = 1'b0;
        #1;
        chk('0, "reset_mid_write", 0);
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        chk('0, "reset_mid_write_hold", 1);
        chk_cnt("count_cleared");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Seventeen jumps: the first fetch after reset proves recovery.
        for (int n = 0; n < 17; n++) begin
            gen_instr(9, 0, 0);
            run_q("jmp");
        end
        chk_cnt("count_wrap_17_jmp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so a stuck run still reports.
    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
Main control FSM of the multi-cycle datapath; the driving end of the ALU interface. Issues the 2-bit ALU op code and operand selects, consumes the ALU zero/negative flags to resolve branches, and sequences fetch/decode/execute/memory/writeback with a ready handshake to the shared instruction/data memory.

Parameters:
OPCODE_W, 4, width of instruction opcode field
CNT_W, 32, width of retired-instruction counter (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward
zer_flag  in  1  ALU result == 0
neg_flag  in  1  ALU result[31]
mem_ready  in  1  memory access completes this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  load IR
reg_write  out  1  register file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  0=add, 1=sub, 2=and, 3=or
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_write  out  1  PC load enable
illegal_op  out  1  one-cycle pulse in DECODE on undefined opcode

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type), 4 ADDI, 5 LW, 6 SW, 7 BZ, 8 BN, 9 JMP, 10-15 illegal.
- Defaults in every state unless listed: all enables 0, muxes 0, alu_op=add.
- While rst_n=0: state=FETCH, all outputs forced 0 (incl. mem_read). Deassertion: first rising edge starts FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00; ir_write=pc_write=mem_ready. Hold while mem_ready=0; -> DECODE when 1.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target to ALUOut). Next: 0-3 EXEC_R; 4 EXEC_I; 5,6 MEM_ADDR; 7,8 BRANCH; 9 JUMP; else illegal_op=1, -> FETCH, no writes.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=opcode[1:0] -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, add -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add -> MEM_RD (LW) / MEM_WR (SW); opcode registered in DECODE, not re-sampled.
- MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01; pc_write = (BZ & zer_flag) | (BN & neg_flag), combinational from same-cycle flags -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- Latencies (mem_ready immediate): R/ADDI 4, LW 5, SW 4, branch/jump 3, illegal 2 cycles.
- mem_read and mem_write never both 1; request held stable until mem_ready.
- Reset mid-access: request drops asynchronously; access abandoned, no register/PC write.

Optional Feature:
CTRL_INSTR_CNT_EN: adds output instr_count [CNT_W-1:0]; clears on reset; increments by 1 on every transition into FETCH from a non-FETCH state (illegal included); wraps at 2^CNT_W. Without macro: port and counter absent, behaviour otherwise identical.

Test Plan:
ADD (opcode 0), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; alu_op=0 in EXEC_R; reg_write=1,reg_dst=1 cycle 4; back in FETCH cycle 5.
LW with mem_ready low 3 cycles in MEM_RD -> mem_read,i_or_d=1 held 4 cycles; MEM_WB asserts reg_write,mem_to_reg=1 once.
BZ with zer_flag=1 -> pc_write=1,pc_src=01,alu_op=1 in BRANCH; repeat with zer_flag=0 -> pc_write=0; BN with neg_flag=1,zer_flag=0 -> pc_write=1.
Opcode 12 -> illegal_op pulse 1 cycle in DECODE, no reg_write/mem_write/pc_write; next state FETCH.
rst_n low mid MEM_WR -> mem_write drops immediately, all outputs 0; after release FETCH with mem_read=1.
CTRL_INSTR_CNT_EN, CNT_W=4: run 17 JMPs -> instr_count reads 1.
